// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
//
// Captures every committed-instruction record from the CPU commit ports into
// a FIFO and hands the records to the difftest harness over a valid/ready
// handshake. The head record is presented first-word fall-through. It also
// tracks the run state (RUN, DRAIN after halt, DONE) and counts accepted
// instructions and active cycles.
//
// Optional feature (macro COMMIT_WATCHDOG_EN): an idle watchdog that raises
// `timeout` and jumps to DONE when no commit arrives for WDOG_LIMIT cycles.
// With the macro undefined, `timeout` is tied to 0.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   commit*              committed record (pc, instr, halt, reg write, dmem write)
//   out_valid/out_ready  head-record handshake to the harness
//   out_*                head record fields (don't-care while out_valid = 0)
//   full                 FIFO holds DEPTH records
//   overflow             sticky: a record was dropped because the FIFO was full
//   done                 halt drained, or watchdog expired
//   timeout              sticky: watchdog expired
//   instr_count          records accepted (mod 2^32)
//   cycle_count          cycles spent in RUN or DRAIN (mod 2^32)

module commit_trace_buffer #(
    parameter int DEPTH          = 16,
    parameter int WDOG_LIMIT     = 1024,
    parameter int DATA_MEM_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      commit,
    input  logic                      commit_halt,
    input  logic [31:0]               commit_pc,
    input  logic [31:0]               commit_instr,
    input  logic                      commit_reg_we,
    input  logic [4:0]                commit_reg_wa,
    input  logic [31:0]               commit_reg_wd,
    input  logic                      commit_dmem_we,
    input  logic [DATA_MEM_DEPTH-1:0] commit_dmem_wa,
    input  logic [31:0]               commit_dmem_wd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_pc,
    output logic [31:0]               out_instr,
    output logic                      out_halt,
    output logic                      out_reg_we,
    output logic [4:0]                out_reg_wa,
    output logic [31:0]               out_reg_wd,
    output logic                      out_dmem_we,
    output logic [DATA_MEM_DEPTH-1:0] out_dmem_wa,
    output logic [31:0]               out_dmem_wd,
    output logic                      full,
    output logic                      overflow,
    output logic                      done,
    output logic                      timeout,
    output logic [31:0]               instr_count,
    output logic [31:0]               cycle_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic                      halt;
        logic [31:0]               pc;
        logic [31:0]               instr;
        logic                      reg_we;
        logic [4:0]                reg_wa;
        logic [31:0]               reg_wd;
        logic                      dmem_we;
        logic [DATA_MEM_DEPTH-1:0] dmem_wa;
        logic [31:0]               dmem_wd;
    } rec_t;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    rec_t            mem [DEPTH];
    rec_t            rec_in, head;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            in_run, push, pop, drop, wdog_fire;
    logic            overflow_r;

    assign rec_in = '{halt:    commit_halt,
                      pc:      commit_pc,
                      instr:   commit_instr,
                      reg_we:  commit_reg_we,
                      reg_wa:  commit_reg_wa,
                      reg_wd:  commit_reg_wd,
                      dmem_we: commit_dmem_we,
                      dmem_wa: commit_dmem_wa,
                      dmem_wd: commit_dmem_wd};

    assign out_valid = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign done      = (state == S_DONE);
    assign overflow  = overflow_r;

    assign in_run = (state == S_RUN);
    assign pop    = out_valid && out_ready;
    // A full FIFO still accepts a record when the head leaves on the same edge.
    assign push   = in_run && commit && (!full || pop);
    assign drop   = in_run && commit && full && !pop;

`ifdef COMMIT_WATCHDOG_EN
    logic [31:0] idle_cnt;
    logic        timeout_r;

    // Fires on the edge where the idle count would reach WDOG_LIMIT.
    assign wdog_fire = in_run && !commit && (idle_cnt == 32'(WDOG_LIMIT - 1));
    assign timeout   = timeout_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt  <= '0;
            timeout_r <= 1'b0;
        end else begin
            if (in_run && !commit)
                idle_cnt <= idle_cnt + 32'd1;
            else
                idle_cnt <= '0;
            if (wdog_fire)
                timeout_r <= 1'b1;
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (wdog_fire)
                    state_nxt = S_DONE;
                else if (commit && commit_halt)
                    state_nxt = S_DRAIN;
            end
            // Leaves on the edge after occupancy has reached zero.
            S_DRAIN: begin
                if (count == '0)
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_RUN;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow_r  <= 1'b0;
            instr_count <= '0;
            cycle_count <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                wr_ptr      <= wr_ptr + PW'(1);
                instr_count <= instr_count + 32'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop)
                overflow_r <= 1'b1;
            if (state != S_DONE)
                cycle_count <= cycle_count + 32'd1;
        end
    end

    // Record storage carries data only and is not reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= rec_in;
    end

    assign head        = mem[rd_ptr];
    assign out_pc      = head.pc;
    assign out_instr   = head.instr;
    assign out_halt    = head.halt;
    assign out_reg_we  = head.reg_we;
    assign out_reg_wa  = head.reg_wa;
    assign out_reg_wd  = head.reg_wd;
    assign out_dmem_we = head.dmem_we;
    assign out_dmem_wa = head.dmem_wa;
    assign out_dmem_wd = head.dmem_wd;

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 16;
`ifdef COMMIT_WATCHDOG_EN
    localparam int WDOG  = 64;
`else
    localparam int WDOG  = 1024;
`endif

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   instr;
        logic          halt;
        logic          reg_we;
        logic [4:0]    reg_wa;
        logic [31:0]   reg_wd;
        logic          dmem_we;
        logic [AW-1:0] dmem_wa;
        logic [31:0]   dmem_wd;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          commit = 1'b0, commit_halt = 1'b0;
    logic [31:0]   commit_pc = '0, commit_instr = '0;
    logic          commit_reg_we = 1'b0;
    logic [4:0]    commit_reg_wa = '0;
    logic [31:0]   commit_reg_wd = '0;
    logic          commit_dmem_we = 1'b0;
    logic [AW-1:0] commit_dmem_wa = '0;
    logic [31:0]   commit_dmem_wd = '0;
    logic          out_valid, out_ready = 1'b0;
    logic [31:0]   out_pc, out_instr, out_reg_wd, out_dmem_wd;
    logic          out_halt, out_reg_we, out_dmem_we;
    logic [4:0]    out_reg_wa;
    logic [AW-1:0] out_dmem_wa;
    logic          full, overflow, done, timeout;
    logic [31:0]   instr_count, cycle_count;

    commit_trace_buffer #(.DEPTH(DEPTH), .WDOG_LIMIT(WDOG), .DATA_MEM_DEPTH(AW)) dut (
        .clk(clk), .rst(rst), .commit(commit), .commit_halt(commit_halt),
        .commit_pc(commit_pc), .commit_instr(commit_instr),
        .commit_reg_we(commit_reg_we), .commit_reg_wa(commit_reg_wa), .commit_reg_wd(commit_reg_wd),
        .commit_dmem_we(commit_dmem_we), .commit_dmem_wa(commit_dmem_wa), .commit_dmem_wd(commit_dmem_wd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_halt(out_halt),
        .out_reg_we(out_reg_we), .out_reg_wa(out_reg_wa), .out_reg_wd(out_reg_wd),
        .out_dmem_we(out_dmem_we), .out_dmem_wa(out_dmem_wa), .out_dmem_wd(out_dmem_wd),
        .full(full), .overflow(overflow), .done(done), .timeout(timeout),
        .instr_count(instr_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    rec_t exp_q[$];
    int   m_occ = 0;
    int   m_state = 0;  // 0 RUN, 1 DRAIN, 2 DONE

    task automatic drive_idle();
        commit      = 1'b0;
        commit_halt = 1'b0;
    endtask

    task automatic drive_commit(input logic [31:0] pc, input logic halt);
        commit         = 1'b1;
        commit_halt    = halt;
        commit_pc      = pc;
        commit_instr   = pc ^ 32'h5555_0013;
        commit_reg_we  = pc[2];
        commit_reg_wa  = pc[6:2];
        commit_reg_wd  = ~pc;
        commit_dmem_we = pc[3];
        commit_dmem_wa = pc[17:2];
        commit_dmem_wd = pc + 32'h100;
    endtask

    // One clock: check any pop against the scoreboard, enqueue any push,
    // advance the reference model, then move to 1 time unit after the edge.
    task automatic step();
        logic p_pop, p_push;
        rec_t r;
        checks++;
        if (out_valid !== (m_occ != 0)) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b", out_valid, (m_occ != 0));
        end
        p_pop = (m_occ != 0) && out_ready;
        if (p_pop) begin
            r = exp_q.pop_front();
            checks++;
            if (out_pc !== r.pc || out_instr !== r.instr || out_halt !== r.halt ||
                out_reg_we !== r.reg_we || out_reg_wa !== r.reg_wa || out_reg_wd !== r.reg_wd ||
                out_dmem_we !== r.dmem_we || out_dmem_wa !== r.dmem_wa || out_dmem_wd !== r.dmem_wd) begin
                errors++;
                $display("FAIL pop_record: got pc=%h instr=%h halt=%b rwe=%b rwa=%h rwd=%h dwe=%b dwa=%h dwd=%h expected pc=%h instr=%h halt=%b rwe=%b rwa=%h rwd=%h dwe=%b dwa=%h dwd=%h",
                         out_pc, out_instr, out_halt, out_reg_we, out_reg_wa, out_reg_wd, out_dmem_we, out_dmem_wa, out_dmem_wd,
                         r.pc, r.instr, r.halt, r.reg_we, r.reg_wa, r.reg_wd, r.dmem_we, r.dmem_wa, r.dmem_wd);
            end
        end
        p_push = (m_state == 0) && commit && ((m_occ < DEPTH) || p_pop);
        if (p_push) begin
            r.pc = commit_pc; r.instr = commit_instr; r.halt = commit_halt;
            r.reg_we = commit_reg_we; r.reg_wa = commit_reg_wa; r.reg_wd = commit_reg_wd;
            r.dmem_we = commit_dmem_we; r.dmem_wa = commit_dmem_wa; r.dmem_wd = commit_dmem_wd;
            exp_q.push_back(r);
        end
        if (m_state == 0 && commit && commit_halt)
            m_state = 1;
        else if (m_state == 1 && m_occ == 0)
            m_state = 2;
        m_occ = m_occ + (p_push ? 1 : 0) - (p_pop ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || full !== 1'b0 || overflow !== 1'b0 || done !== 1'b0 ||
            timeout !== 1'b0 || instr_count !== 32'd0 || cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: got valid=%b full=%b ovf=%b done=%b to=%b ic=%0d cc=%0d expected all 0",
                     out_valid, full, overflow, done, timeout, instr_count, cycle_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_occ = 0;
        m_state = 0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        drive_commit(32'h1c00_0000, 1'b0);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h1c00_0000) begin
            errors++;
            $display("FAIL basic_latency: got valid=%b pc=%h expected valid=1 pc=1c000000", out_valid, out_pc);
        end
        drive_commit(32'h1c00_0004, 1'b0); step();
        drive_commit(32'h1c00_0008, 1'b0); step();
        drive_idle();
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (instr_count !== 32'd3 || full !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_counts: got ic=%0d full=%b valid=%b expected ic=3 full=0 valid=0",
                     instr_count, full, out_valid);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_commit(32'h1c00_0100 + 32'(4 * i), 1'b0);
            step();
        end
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got full=%b ovf=%b expected full=1 ovf=0", full, overflow);
        end
        drive_commit(32'h1c00_0140, 1'b0);
        step();
        checks++;
        if (overflow !== 1'b1 || instr_count !== 32'd16 || full !== 1'b1) begin
            errors++;
            $display("FAIL fill_overflow: got ovf=%b ic=%0d full=%b expected ovf=1 ic=16 full=1",
                     overflow, instr_count, full);
        end
        drive_idle();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) step();
        checks++;
        if (out_valid !== 1'b0 || full !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL fill_drain: got valid=%b full=%b ovf=%b expected valid=0 full=0 ovf=1",
                     out_valid, full, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_commit(32'h1c00_0200 + 32'(4 * i), 1'b0);
            step();
        end
        out_ready = 1'b1;
        drive_commit(32'h1c00_02fc, 1'b0);
        step();
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0 || instr_count !== 32'd17) begin
            errors++;
            $display("FAIL full_push_pop: got full=%b ovf=%b ic=%0d expected full=1 ovf=0 ic=17",
                     full, overflow, instr_count);
        end
        drive_idle();
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h1c00_02fc) begin
            errors++;
            $display("FAIL full_last_out: got valid=%b pc=%h expected valid=1 pc=1c0002fc", out_valid, out_pc);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_halt_drain();
        logic [31:0] frozen;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_commit(32'h1c00_0300 + 32'(4 * i), 1'b0);
            step();
        end
        drive_commit(32'h1c00_0310, 1'b1);
        step();
        for (int i = 0; i < 5; i++) begin
            drive_commit(32'hdead_0000 + 32'(4 * i), 1'b0);
            step();
        end
        checks++;
        if (done !== 1'b0 || instr_count !== 32'd5 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL drain_hold: got done=%b ic=%0d ovf=%b expected done=0 ic=5 ovf=0",
                     done, instr_count, overflow);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL drain_early_done: got done=%b expected 0 at pop %0d", done, i);
            end
            drive_commit(32'hbeef_0000 + 32'(4 * i), 1'b0);
            step();
        end
        drive_idle();
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got done=%b valid=%b expected done=0 valid=0", done, out_valid);
        end
        step();
        checks++;
        if (done !== 1'b1 || cycle_count !== 32'd16 || instr_count !== 32'd5) begin
            errors++;
            $display("FAIL drain_done: got done=%b cc=%0d ic=%0d expected done=1 cc=16 ic=5",
                     done, cycle_count, instr_count);
        end
        frozen = cycle_count;
        drive_commit(32'hcafe_0000, 1'b0);
        for (int i = 0; i < 3; i++) step();
        drive_idle();
        checks++;
        if (cycle_count !== frozen || done !== 1'b1 || instr_count !== 32'd5) begin
            errors++;
            $display("FAIL done_frozen: got cc=%0d done=%b ic=%0d expected cc=%0d done=1 ic=5",
                     cycle_count, done, instr_count, frozen);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_commit(32'h1c00_0400 + 32'(4 * i), 1'b0);
            step();
        end
        drive_idle();
        checks++;
        if (out_valid !== 1'b1 || instr_count !== 32'd5) begin
            errors++;
            $display("FAIL pre_reset: got valid=%b ic=%0d expected valid=1 ic=5", out_valid, instr_count);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || instr_count !== 32'd0 || cycle_count !== 32'd0 ||
            full !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b ic=%0d cc=%0d full=%b done=%b ovf=%b expected all 0",
                     out_valid, instr_count, cycle_count, full, done, overflow);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_occ = 0;
        m_state = 0;
        drive_commit(32'h1c00_0500, 1'b0);
        step();
        drive_idle();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h1c00_0500 || instr_count !== 32'd1) begin
            errors++;
            $display("FAIL post_reset_head: got valid=%b pc=%h ic=%0d expected valid=1 pc=1c000500 ic=1",
                     out_valid, out_pc, instr_count);
        end
        out_ready = 1'b1;
        step();
        step();
    endtask

    task automatic test_watchdog();
        do_reset();
        out_ready = 1'b1;
`ifdef COMMIT_WATCHDOG_EN
        for (int i = 0; i < WDOG - 1; i++) step();
        checks++;
        if (timeout !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL wdog_early: got to=%b done=%b expected 0 0", timeout, done);
        end
        step();
        checks++;
        if (timeout !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL wdog_fire: got to=%b done=%b expected 1 1", timeout, done);
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (timeout !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL wdog_sticky: got to=%b done=%b expected 1 1", timeout, done);
        end
`else
        for (int i = 0; i < 100; i++) step();
        checks++;
        if (timeout !== 1'b0 || done !== 1'b0 || cycle_count !== 32'd100) begin
            errors++;
            $display("FAIL no_wdog: got to=%b done=%b cc=%0d expected to=0 done=0 cc=100",
                     timeout, done, cycle_count);
        end
`endif
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_push_pop();
        test_halt_drain();
        test_reset_mid_run();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
